// File: rtl/spi_frame_ctrl.sv
// SPI byte-stream framing controller: loads 16-bit samples into the FFT sample RAM
// and streams FFT results back out, one byte per SPI transfer.
module spi_frame_ctrl #(
  parameter int N_SAMPLES = 64,
  parameter int AW        = $clog2(N_SAMPLES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          slave_sel,
  input  logic          send_complete,
  input  logic [7:0]    rx_byte,
  output logic          new_byte,
  output logic [7:0]    tx_byte,
  output logic          samp_we,
  output logic [AW-1:0] samp_addr,
  output logic [15:0]   samp_data,
  output logic          frame_loaded,
  input  logic          res_valid,
  output logic [AW-1:0] res_addr,
  input  logic [15:0]   res_data,
  output logic          busy
);

  typedef enum logic [2:0] {IDLE, CMD, LOAD, READ, DRAIN} state_t;

  localparam logic [AW-1:0] LAST_IDX  = AW'(N_SAMPLES - 1);
  localparam logic [7:0]    CMD_LOAD  = 8'h01;
  localparam logic [7:0]    CMD_READ  = 8'h02;
  localparam logic [7:0]    TX_NODATA = 8'hEE;

  state_t        state, state_nxt;
  logic [1:0]    ss_sync, sc_sync;
  logic          ss_d, sc_d;
  logic          ss_s, sc_s;
  logic          ss_fall, ss_rise, byte_evt;
  logic          byte_vld;
  logic [7:0]    rx_reg;
  logic [7:0]    msb;
  logic          phase;
  logic [AW-1:0] idx;
  logic [1:0]    rd_cnt;
  logic          loaded_flag;
  logic [7:0]    status;

  assign ss_s     = ss_sync[1];
  assign sc_s     = sc_sync[1];
  assign ss_fall  = ss_d & ~ss_s;
  assign ss_rise  = ~ss_d & ss_s;
  assign byte_evt = sc_s & ~sc_d & ~new_byte;
  assign busy     = (state != IDLE);
  assign status   = {6'b0, res_valid, loaded_flag};

  // Synchronizers, byte capture and the new_byte handshake (independent of state).
  always_ff @(posedge clk) begin
    if (reset) begin
      ss_sync  <= 2'b11;
      ss_d     <= 1'b1;
      sc_sync  <= '0;
      sc_d     <= 1'b0;
      new_byte <= 1'b0;
      byte_vld <= 1'b0;
      rx_reg   <= '0;
    end else begin
      ss_sync  <= {ss_sync[0], slave_sel};
      ss_d     <= ss_s;
      sc_sync  <= {sc_sync[0], send_complete};
      sc_d     <= sc_s;
      byte_vld <= byte_evt;
      if (byte_evt) begin
        rx_reg   <= rx_byte;
        new_byte <= 1'b1;
      end else if (new_byte && !sc_s) begin
        new_byte <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Bytes are acted on one cycle after capture, so a select fall coinciding with
  // a byte event has already moved the FSM into CMD when that byte is decoded.
  always_comb begin
    state_nxt = state;
    if (ss_rise) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (ss_fall) state_nxt = CMD;
        CMD: begin
          if (byte_vld) begin
            if (rx_reg == CMD_LOAD)      state_nxt = LOAD;
            else if (rx_reg == CMD_READ) state_nxt = res_valid ? READ : DRAIN;
            else                         state_nxt = DRAIN;
          end
        end
        LOAD: if (byte_vld && phase && idx == LAST_IDX) state_nxt = DRAIN;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_byte      <= '0;
      samp_we      <= 1'b0;
      samp_addr    <= '0;
      samp_data    <= '0;
      frame_loaded <= 1'b0;
      res_addr     <= '0;
      loaded_flag  <= 1'b0;
      idx          <= '0;
      phase        <= 1'b0;
      msb          <= '0;
      rd_cnt       <= '0;
    end else begin
      samp_we      <= 1'b0;
      frame_loaded <= 1'b0;
      if (frame_loaded) loaded_flag <= 1'b1;
      if (rd_cnt != '0) rd_cnt <= rd_cnt - 2'd1;
      // rd_cnt==1: res_addr has been stable long enough for res_data to follow it
      if (state == READ && rd_cnt == 2'd1) tx_byte <= res_data[15:8];
      if (state == IDLE || state == CMD)   tx_byte <= status;

      if (ss_rise) begin
        idx      <= '0;
        res_addr <= '0;
        phase    <= 1'b0;
        rd_cnt   <= '0;
      end else if (byte_vld) begin
        case (state)
          CMD: begin
            phase <= 1'b0;
            if (rx_reg == CMD_LOAD) begin
              loaded_flag <= 1'b0;
              idx         <= '0;
            end else if (rx_reg == CMD_READ) begin
              res_addr <= '0;
              if (res_valid) rd_cnt  <= 2'd2;
              else           tx_byte <= TX_NODATA;
            end
          end
          LOAD: begin
            if (!phase) begin
              msb   <= rx_reg;
              phase <= 1'b1;
            end else begin
              samp_we   <= 1'b1;
              samp_data <= {msb, rx_reg};
              samp_addr <= idx;
              idx       <= idx + AW'(1);
              phase     <= 1'b0;
              if (idx == LAST_IDX) frame_loaded <= 1'b1;
            end
          end
          READ: begin
            if (rd_cnt == '0) begin
              if (!phase) begin
                tx_byte <= res_data[7:0];
                phase   <= 1'b1;
              end else begin
                res_addr <= res_addr + AW'(1);
                phase    <= 1'b0;
                rd_cnt   <= 2'd2;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl with N_SAMPLES=4: sample-write and
// tx-byte scoreboards fed as stimulus is driven.
module tb_spi_frame_ctrl;
  localparam int N  = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          reset, slave_sel, send_complete, res_valid;
  logic [7:0]    rx_byte;
  logic          new_byte, samp_we, frame_loaded, busy;
  logic [7:0]    tx_byte;
  logic [AW-1:0] samp_addr, res_addr;
  logic [15:0]   samp_data, res_data;
  logic [15:0]   mem [N];

  int checks   = 0;
  int failures = 0;
  logic [31:0] wr_q[$];
  logic [31:0] tx_q[$];

  always #5 clk = ~clk;

  spi_frame_ctrl #(.N_SAMPLES(N)) dut (
    .clk(clk), .reset(reset), .slave_sel(slave_sel), .send_complete(send_complete),
    .rx_byte(rx_byte), .new_byte(new_byte), .tx_byte(tx_byte),
    .samp_we(samp_we), .samp_addr(samp_addr), .samp_data(samp_data),
    .frame_loaded(frame_loaded), .res_valid(res_valid), .res_addr(res_addr),
    .res_data(res_data), .busy(busy)
  );

  always @(posedge clk) res_data <= mem[res_addr];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_wr(input logic fl, input logic [AW-1:0] a, input logic [15:0] d);
    return {13'd0, fl, a, d};
  endfunction

  always @(negedge clk) begin
    if (samp_we) begin
      if (wr_q.size() == 0) check("unexp_we", 32'(samp_we), 32'd0);
      else check("samp_wr", {13'd0, frame_loaded, samp_addr, samp_data}, wr_q.pop_front());
    end else if (frame_loaded) begin
      check("stray_fl", 32'(frame_loaded), 32'd0);
    end
  end

  task automatic xfer(input logic [7:0] b, input int hold);
    int t;
    rx_byte       = b;
    send_complete = 1'b1;
    repeat (hold) @(negedge clk);
    send_complete = 1'b0;
    t = 0;
    while (new_byte !== 1'b0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (new_byte !== 1'b0) check("hs_timeout", 32'(new_byte), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    xfer(b, 4);
  endtask

  task automatic sel_low();
    slave_sel = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic sel_high();
    slave_sel = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic load_sample(input logic [15:0] d, input logic [AW-1:0] a, input logic fl);
    send_byte(d[15:8]);
    wr_q.push_back(exp_wr(fl, a, d));
    send_byte(d[7:0]);
  endtask

  task automatic check_reset(input string p);
    check({p, "_new_byte"},  32'(new_byte),     32'd0);
    check({p, "_tx_byte"},   32'(tx_byte),      32'd0);
    check({p, "_samp_we"},   32'(samp_we),      32'd0);
    check({p, "_samp_addr"}, 32'(samp_addr),    32'd0);
    check({p, "_samp_data"}, 32'(samp_data),    32'd0);
    check({p, "_frame_ld"},  32'(frame_loaded), 32'd0);
    check({p, "_res_addr"},  32'(res_addr),     32'd0);
    check({p, "_busy"},      32'(busy),         32'd0);
  endtask

  initial begin
    int cyc;
    logic [31:0] e;
    reset = 1'b1; slave_sel = 1'b1; send_complete = 1'b0; rx_byte = '0; res_valid = 1'b0;
    mem[0] = 16'hA1B2; mem[1] = 16'hC3D4; mem[2] = 16'hE5F6; mem[3] = 16'h0718;
    repeat (3) @(negedge clk);
    check_reset("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_status", 32'(tx_byte), 32'h00);
    check("idle_busy",   32'(busy),    32'd0);

    // Full frame load
    sel_low();
    check("cmd_busy", 32'(busy), 32'd1);
    send_byte(8'h01);
    load_sample(16'h1234, 2'd0, 1'b0);
    load_sample(16'h5678, 2'd1, 1'b0);
    load_sample(16'h9ABC, 2'd2, 1'b0);
    load_sample(16'hDEF0, 2'd3, 1'b1);
    check("load_sb", 32'(wr_q.size()), 32'd0);
    send_byte(8'h77);
    send_byte(8'h88);
    check("drain_tx",   32'(tx_byte), 32'h00);
    check("drain_busy", 32'(busy),    32'd1);
    sel_high();
    check("abort_busy",   32'(busy),    32'd0);
    check("loaded_stat",  32'(tx_byte), 32'h01);

    // Read with results valid, including address wrap
    res_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("valid_stat", 32'(tx_byte), 32'h03);
    sel_low();
    send_byte(8'h02);
    check("rd_first_tx",   32'(tx_byte),  32'hA1);
    check("rd_first_addr", 32'(res_addr), 32'd0);
    tx_q.push_back({22'd0, 2'd0, 8'hB2}); tx_q.push_back({22'd0, 2'd1, 8'hC3});
    tx_q.push_back({22'd0, 2'd1, 8'hD4}); tx_q.push_back({22'd0, 2'd2, 8'hE5});
    tx_q.push_back({22'd0, 2'd2, 8'hF6}); tx_q.push_back({22'd0, 2'd3, 8'h07});
    tx_q.push_back({22'd0, 2'd3, 8'h18}); tx_q.push_back({22'd0, 2'd0, 8'hA1});
    while (tx_q.size() != 0) begin
      send_byte(8'h5A);
      e = tx_q.pop_front();
      check("rd_tx_addr", {22'd0, res_addr, tx_byte}, e);
    end
    sel_high();

    // Read with no results available
    res_valid = 1'b0;
    sel_low();
    send_byte(8'h02);
    check("nores_tx",   32'(tx_byte),  32'hEE);
    check("nores_addr", 32'(res_addr), 32'd0);
    check("nores_busy", 32'(busy),     32'd1);
    send_byte(8'h33);
    check("nores_hold", 32'(tx_byte),  32'hEE);
    sel_high();

    // Abort after a partial sample, then a fresh frame with a long handshake
    sel_low();
    send_byte(8'h01);
    send_byte(8'h12);
    sel_high();
    check("abort2_busy", 32'(busy),    32'd0);
    check("abort2_stat", 32'(tx_byte), 32'h00);
    sel_low();
    send_byte(8'h01);
    rx_byte = 8'hAB;
    send_complete = 1'b1;
    repeat (10) @(negedge clk);
    check("hs_high", 32'(new_byte), 32'd1);
    send_complete = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      cyc = i;
      if (new_byte == 1'b0) break;
    end
    check("hs_lat_ok", 32'((cyc >= 2 && cyc <= 3) ? 1 : 0), 32'd1);
    repeat (3) @(negedge clk);
    wr_q.push_back(exp_wr(1'b0, 2'd0, 16'hABCD));
    send_byte(8'hCD);
    check("abort_sb", 32'(wr_q.size()), 32'd0);
    sel_high();

    // Select fall coinciding with the command byte
    slave_sel = 1'b0;
    send_byte(8'h01);
    load_sample(16'h5566, 2'd0, 1'b0);
    check("coinc_sb", 32'(wr_q.size()), 32'd0);
    sel_high();

    // Reset in the middle of a load
    sel_low();
    send_byte(8'h01);
    load_sample(16'h1111, 2'd0, 1'b0);
    load_sample(16'h2222, 2'd1, 1'b0);
    load_sample(16'h3333, 2'd2, 1'b0);
    send_byte(8'h44);
    reset = 1'b1;
    slave_sel = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("rst2");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst2_status", 32'(tx_byte), 32'h00);
    send_byte(8'h55);
    check("rst2_busy", 32'(busy), 32'd0);

    check("sb_drain", 32'(wr_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
